// File: rtl/am_retune_seq.sv
// am_retune_seq: click-free retune/enable sequencer for the NCO/modulator bank.
// Visits channels round-robin. A channel whose requested increment or enable
// differs from what is applied gets its gain ramped to zero, its increment
// swapped with an NCO phase reset, and its gain ramped back up.
module am_retune_seq #(
  parameter int unsigned NUM_CHANNELS = 12,
  parameter int unsigned GAIN_W       = 8,
  parameter int unsigned RAMP_DIV     = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           master_enable,
  input  logic [NUM_CHANNELS-1:0]        channel_enable,
  input  logic [32*NUM_CHANNELS-1:0]     req_phase_inc,
  output logic [32*NUM_CHANNELS-1:0]     nco_phase_inc,
  output logic [NUM_CHANNELS-1:0]        nco_phase_rst,
  output logic [GAIN_W*NUM_CHANNELS-1:0] ch_gain,
  output logic [NUM_CHANNELS-1:0]        ch_active,
  output logic                           busy,
  output logic [3:0]                     cur_ch
);

  localparam logic [GAIN_W-1:0] GAIN_MAX      = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE      = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_NEAR_MAX = GAIN_MAX - GAIN_ONE;
  localparam int unsigned       DIV_W         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE       = DIV_W'(1);
  localparam logic [3:0]        LAST_CH       = 4'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    SCAN,
    RAMP_DOWN,
    SWAP,
    RAMP_UP
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CHANNELS-1:0][31:0]       applied_inc;
  logic [NUM_CHANNELS-1:0][GAIN_W-1:0] gain;
  logic [NUM_CHANNELS-1:0]             applied_en;
  logic [NUM_CHANNELS-1:0][31:0]       req;
  logic [3:0]                          ptr;
  logic [DIV_W-1:0]                    div;
  logic [31:0]                         tgt_inc;
  logic                                tgt_en;

  logic              want_en;
  logic              mismatch;
  logic              div_tc;
  logic [GAIN_W-1:0] cur_gain;
  logic [3:0]        ptr_inc;

  assign req = req_phase_inc;

  // Compare the pointed-to channel's request against what is applied.
  always_comb begin
    want_en  = master_enable & channel_enable[ptr];
    cur_gain = gain[ptr];
    mismatch = (want_en != applied_en[ptr]) ||
               (want_en && (req[ptr] != applied_inc[ptr]));
    div_tc   = (div == DIV_LAST);
    ptr_inc  = (ptr == LAST_CH) ? '0 : ptr + 4'd1;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN: begin
        if (mismatch)
          state_nxt = (applied_en[ptr] && (cur_gain != '0)) ? RAMP_DOWN : SWAP;
      end
      RAMP_DOWN: begin
        if ((cur_gain == '0) || (div_tc && (cur_gain == GAIN_ONE)))
          state_nxt = SWAP;
      end
      SWAP: begin
        state_nxt = tgt_en ? RAMP_UP : SCAN;
      end
      RAMP_UP: begin
        if ((cur_gain == GAIN_MAX) || (div_tc && (cur_gain == GAIN_NEAR_MAX)))
          state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= SCAN;
    else       state <= state_nxt;
  end

  // Per-channel applied state, pointer, divider and snapshot registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      applied_inc   <= '0;
      applied_en    <= '0;
      gain          <= '0;
      nco_phase_rst <= '0;
      ptr           <= '0;
      div           <= '0;
      tgt_inc       <= '0;
      tgt_en        <= 1'b0;
    end else begin
      nco_phase_rst <= '0;
      unique case (state)
        SCAN: begin
          if (mismatch) begin
            tgt_inc <= req[ptr];
            tgt_en  <= want_en;
            div     <= '0;
          end else begin
            ptr <= ptr_inc;
          end
        end
        RAMP_DOWN: begin
          if (div_tc) begin
            div <= '0;
            if (cur_gain != '0) gain[ptr] <= cur_gain - GAIN_ONE;
          end else begin
            div <= div + DIV_ONE;
          end
        end
        SWAP: begin
          applied_en[ptr] <= tgt_en;
          div             <= '0;
          if (tgt_en) begin
            applied_inc[ptr]   <= tgt_inc;
            nco_phase_rst[ptr] <= 1'b1;
          end else begin
            ptr <= ptr_inc;
          end
        end
        RAMP_UP: begin
          if (cur_gain == GAIN_MAX) begin
            ptr <= ptr_inc;
          end else if (div_tc) begin
            div       <= '0;
            gain[ptr] <= cur_gain + GAIN_ONE;
            if (cur_gain == GAIN_NEAR_MAX) ptr <= ptr_inc;
          end else begin
            div <= div + DIV_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign nco_phase_inc = applied_inc;
  assign ch_gain       = gain;
  assign ch_active     = applied_en;
  assign busy          = (state != SCAN);
  assign cur_ch        = ptr;

endmodule
